// File: rtl/onehot_decoder_seq.sv
// Streaming binary-index to one-hot decoder: a small FIFO feeds a registered
// one-hot output stage, with a sticky mask of every line delivered.
module onehot_decoder_seq #(
  parameter  int IDX_W = 3,
  parameter  int DEPTH = 2,
  localparam int OUT_W = 2 ** IDX_W,
  localparam int LVL_W = $clog2(DEPTH + 2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [IDX_W-1:0] i_in_idx,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [OUT_W-1:0] o_out,
  output logic [OUT_W-1:0] o_mask,
  input  logic             i_clr_mask,
  output logic [LVL_W-1:0] o_level
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [IDX_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [OUT_W-1:0] r_out;
  logic             r_out_valid;
  logic [OUT_W-1:0] r_mask;
  logic [LVL_W-1:0] r_level;

  logic             w_full;
  logic             w_nonempty;
  logic             w_push;
  logic             w_load;
  logic             w_deliver;
  logic [IDX_W-1:0] w_head;
  logic [OUT_W-1:0] w_decoded;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_valid_nxt;
  logic [LVL_W-1:0] w_level_nxt;
  logic [OUT_W-1:0] w_mask_nxt;

  // Intake looks only at the FIFO's own fullness, never at a same-cycle pop,
  // so in_ready has no path from out_ready.
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_nonempty = (r_count != '0);
  assign o_in_ready = i_en && !w_full;
  assign w_push     = i_in_valid && o_in_ready;
  assign w_deliver  = r_out_valid && i_out_ready;
  assign w_load     = i_en && w_nonempty && (!r_out_valid || i_out_ready);
  assign w_head     = r_mem[r_rd_ptr];
  assign w_decoded  = OUT_W'(1) << w_head;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_load) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!w_push && w_load) begin
      w_count_nxt = r_count - CNT_W'(1);
    end

    w_valid_nxt = r_out_valid;
    if (w_load) begin
      w_valid_nxt = 1'b1;
    end else if (w_deliver) begin
      w_valid_nxt = 1'b0;
    end

    w_level_nxt = LVL_W'(w_count_nxt) + LVL_W'(w_valid_nxt);
    w_mask_nxt  = (i_clr_mask ? '0 : r_mask) | (w_deliver ? r_out : '0);
  end

  // Storage needs no reset: resetting the pointers and count discards it.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_in_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_load) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  // The output word is forced to zero whenever it is not valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_mask      <= '0;
      r_level     <= '0;
    end else begin
      if (w_load) begin
        r_out <= w_decoded;
      end else if (w_deliver) begin
        r_out <= '0;
      end
      r_out_valid <= w_valid_nxt;
      r_mask      <= w_mask_nxt;
      r_level     <= w_level_nxt;
    end
  end

  assign o_out       = r_out;
  assign o_out_valid = r_out_valid;
  assign o_mask      = r_mask;
  assign o_level     = r_level;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Directed-vector bench for onehot_decoder_seq (IDX_W=3, DEPTH=2); every
// expected value below is worked out by hand from the block's behaviour.
module tb_onehot_decoder_seq;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       inValid;
  logic       inReady;
  logic [2:0] inIdx;
  logic       outValid;
  logic       outReady;
  logic [7:0] outWord;
  logic [7:0] mask;
  logic       clrMask;
  logic [1:0] level;

  int vectorCount = 0;
  int missCount = 0;

  onehot_decoder_seq #(.IDX_W(3), .DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (en),
    .i_in_valid (inValid),
    .o_in_ready (inReady),
    .i_in_idx   (inIdx),
    .o_out_valid(outValid),
    .i_out_ready(outReady),
    .o_out      (outWord),
    .o_mask     (mask),
    .i_clr_mask (clrMask),
    .o_level    (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic e, input logic v, input logic [2:0] idx,
                               input logic ordy, input logic clr);
    en       = e;
    inValid  = v;
    inIdx    = idx;
    outReady = ordy;
    clrMask  = clr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectorCount++;
    assert (obs === exp)
    else begin
      missCount++;
      $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    tick();

    // Reset state
    checkOutput("rst_out", 32'(outWord), 32'h0);
    checkOutput("rst_valid", 32'(outValid), 32'h0);
    checkOutput("rst_mask", 32'(mask), 32'h0);
    checkOutput("rst_level", 32'(level), 32'h0);
    checkOutput("rst_ready_en0", 32'(inReady), 32'h0);
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
    #1;
    checkOutput("rst_ready_en1", 32'(inReady), 32'h1);
    tick();
    rst_n = 1'b1;

    // Stream 0..7 with out_ready high: each word two edges after its push
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 1'b1, 3'(k), 1'b1, 1'b0);
      tick();
      if (k >= 1) begin
        checkOutput($sformatf("stream_out%0d", k - 1), 32'(outWord), 32'(1) << (k - 1));
        checkOutput($sformatf("stream_vld%0d", k - 1), 32'(outValid), 32'h1);
      end
      if (k == 4) checkOutput("stream_level", 32'(level), 32'h2);
    end
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
    tick();
    checkOutput("stream_out7", 32'(outWord), 32'h80);
    tick();
    checkOutput("stream_drain_out", 32'(outWord), 32'h0);
    checkOutput("stream_drain_vld", 32'(outValid), 32'h0);
    checkOutput("stream_mask", 32'(mask), 32'hFF);
    checkOutput("stream_level0", 32'(level), 32'h0);

    // Clear alone
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b1, 1'b1);
    tick();
    checkOutput("clr_alone", 32'(mask), 32'h0);

    // Backpressure: push 5,3,6 with out_ready low
    applyStimulus(1'b1, 1'b1, 3'd5, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 3'd3, 1'b0, 1'b0);
    tick();
    checkOutput("bp_out_first", 32'(outWord), 32'h20);
    applyStimulus(1'b1, 1'b1, 3'd6, 1'b0, 1'b0);
    tick();
    checkOutput("bp_level3", 32'(level), 32'h3);
    checkOutput("bp_ready_full", 32'(inReady), 32'h0);
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    checkOutput("bp_hold", 32'(outWord), 32'h20);
    checkOutput("bp_hold_level", 32'(level), 32'h3);

    // Full FIFO with in_valid and out_ready together: push refused this edge
    applyStimulus(1'b1, 1'b1, 3'd1, 1'b1, 1'b0);
    #1;
    checkOutput("full_pop_ready", 32'(inReady), 32'h0);
    tick();
    checkOutput("full_pop_out", 32'(outWord), 32'h08);
    checkOutput("full_pop_level", 32'(level), 32'h2);
    checkOutput("full_pop_ready_after", 32'(inReady), 32'h1);
    tick();
    checkOutput("after_push_out", 32'(outWord), 32'h40);
    checkOutput("after_push_level", 32'(level), 32'h2);
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
    tick();
    checkOutput("late_word_out", 32'(outWord), 32'h02);
    checkOutput("late_word_level", 32'(level), 32'h1);
    tick();
    checkOutput("bp_end_vld", 32'(outValid), 32'h0);
    checkOutput("bp_end_level", 32'(level), 32'h0);
    checkOutput("bp_mask", 32'(mask), 32'h6A);

    // Build mask 0x28, then clear coincident with delivery of 0x01
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b1, 3'd5, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 3'd3, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
    tick();
    tick();
    checkOutput("mask_28", 32'(mask), 32'h28);
    applyStimulus(1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
    tick();
    checkOutput("mask_pre_clr_out", 32'(outWord), 32'h01);
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b1, 1'b1);
    tick();
    checkOutput("mask_clr_deliver", 32'(mask), 32'h01);

    // Enable dropped with two buffered entries and a valid word
    applyStimulus(1'b1, 1'b1, 3'd2, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 3'd4, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 3'd7, 1'b0, 1'b0);
    tick();
    checkOutput("en_setup_out", 32'(outWord), 32'h04);
    applyStimulus(1'b0, 1'b1, 3'd1, 1'b1, 1'b0);
    #1;
    checkOutput("en0_ready", 32'(inReady), 32'h0);
    tick();
    checkOutput("en0_drain_vld", 32'(outValid), 32'h0);
    checkOutput("en0_drain_out", 32'(outWord), 32'h0);
    checkOutput("en0_level", 32'(level), 32'h2);
    tick();
    checkOutput("en0_noload_vld", 32'(outValid), 32'h0);
    checkOutput("en0_noload_level", 32'(level), 32'h2);
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
    tick();
    checkOutput("en1_out", 32'(outWord), 32'h10);
    tick();
    checkOutput("en1_out2", 32'(outWord), 32'h80);
    tick();
    checkOutput("en1_empty", 32'(level), 32'h0);

    // Asynchronous reset mid-stream with level 3
    applyStimulus(1'b1, 1'b1, 3'd1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 3'd2, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 3'd3, 1'b0, 1'b0);
    tick();
    checkOutput("arst_pre_level", 32'(level), 32'h3);
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_out", 32'(outWord), 32'h0);
    checkOutput("arst_vld", 32'(outValid), 32'h0);
    checkOutput("arst_mask", 32'(mask), 32'h0);
    checkOutput("arst_level", 32'(level), 32'h0);
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 3'd6, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
    tick();
    checkOutput("post_rst_out", 32'(outWord), 32'h40);
    checkOutput("post_rst_level", 32'(level), 32'h1);
    tick();
    checkOutput("post_rst_empty", 32'(level), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/onehot_decoder_seq.md
Name: onehot_decoder_seq

Overview:
- Streaming index-to-one-hot decoder: the inverse of the team's 8-to-3 priority encoder.
- Accepts binary indices over a valid/ready handshake and buffers them in a small FIFO.
- Presents each index as a registered one-hot word on a valid/ready output.
- Keeps a sticky accumulated mask of every line delivered; used to re-expand encoded request indices into per-line grant/ack vectors.

Parameters:
- IDX_W, 3, index width; OUT_W = 2**IDX_W (8 by default).
- DEPTH, 2, FIFO entries ahead of the output register; power of 2, >= 2.
- LVL_W, $clog2(DEPTH+2), width of the occupancy count (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  block enable; low freezes intake and output refill.
- in_valid  input  1  in_idx valid.
- in_ready  output  1  block can accept; = en && !fifo_full (combinational).
- in_idx  input  IDX_W  binary index to decode.
- out_valid  output  1  out holds a valid one-hot word.
- out_ready  input  1  consumer accepts out.
- out  output  OUT_W  registered one-hot word, bit in_idx set.
- mask  output  OUT_W  sticky OR of all delivered one-hot words.
- clr_mask  input  1  synchronous clear of mask.
- level  output  LVL_W  entries held: FIFO count + out_valid, range 0..DEPTH+1.

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset (rst_n low, at any time, including mid-transfer):
  - out=0, out_valid=0, mask=0, level=0.
  - FIFO pointers and count = 0; all buffered entries are discarded.
  - in_ready=1 after reset only if en=1.
- Push: when in_valid && in_ready at the clk edge, in_idx is written at the FIFO tail.
  - in_ready does not depend on out_ready or same-cycle pop. A full FIFO refuses input even if a pop occurs.
- Load: at the clk edge the output register loads the decoded FIFO head when en && fifo_nonempty && (!out_valid || out_ready).
  - out <= 1 << head; out_valid <= 1; the FIFO pops.
- Drain: on out_valid && out_ready with no load, out_valid <= 0 and out <= 0.
  - out is all-zero whenever out_valid=0.
- Latency: an index accepted at edge N appears on out with out_valid=1 after edge N+1, provided the output is free. No combinational in-to-out path.
- Back-to-back: with out_ready held high, one word per cycle is sustained.
- Backpressure: out_valid=1 && out_ready=0 holds out stable. The FIFO fills; in_ready drops when count = DEPTH.
- Simultaneous push and pop on a non-full FIFO: the count is unchanged and the pointers advance independently. Pointers wrap modulo DEPTH.
- en=0:
  - No push (in_ready=0) and no load.
  - An already-valid out may still complete its handshake and drain.
  - Contents are preserved.
- mask update at the edge:
  - mask <= (clr_mask ? 0 : mask) | (out_valid && out_ready ? out : 0).
  - A clear coincident with a delivery leaves exactly the delivered bit set.
- level: count of FIFO entries plus out_valid, registered, updated every edge.
- Decoding is total: every in_idx value is legal. There is no error path and no X on out.

Test Plan:
- Reset then en=1, push idx 0..7 with out_ready=1 -> out = 0x01,0x02,...,0x80 on consecutive cycles, each 2 edges after its push; final mask=0xFF.
- out_ready=0, push 5,3,6 -> out=0x20 held; FIFO full after 3 accepts (DEPTH=2); in_ready=0; level=3. Release out_ready -> 0x20,0x08,0x40 delivered in order; level returns to 0.
- Full FIFO, in_valid=1 and out_ready=1 in the same cycle -> no push that cycle (in_ready=0); push accepted the next cycle; no index lost or duplicated.
- mask=0x28 and clr_mask=1 coincident with delivery of 0x01 -> mask=0x01 next cycle. clr_mask alone -> mask=0x00.
- en dropped with 2 entries buffered and out_valid=1 -> current word drains on out_ready; no further load while en=0; re-enable -> remaining entry appears the next edge.
- rst_n asserted asynchronously mid-stream with level=3 -> out, out_valid, mask and level all 0 immediately. After release, the first new push decodes correctly with no stale entries.
